partitioned_cache_set: RTL and testbench
========================================

// Module: partitioned_cache_set
// PURPOSE
//  Way-partitioned, NRU-replaced cache set; the responder behind the cacheline request interface.
//  Accepts OS requests (load the partition hitmap) and user requests (tag lookup/fill) over valid/ready.
//  Returns hit/way over valid/ready. Exposes policy/metadata/tag/valid state for formal isolation proofs.
//  Requests outside the active partition never read or modify state belonging to other ways.
// PARAMETERS
//  NUM_WAYS    8   ways in the set (>=2)
//  ADDR_WIDTH  4   tag width in bits
//  WAY_W       $clog2(NUM_WAYS)   localparam, width of the way index
// PORTS
//  clk              in   1                    clock, all state on posedge
//  reset_n          in   1                    asynchronous active-low reset
//  req_valid        in   1                    request present
//  req_ready        out  1                    request accepted when valid&ready
//  req_os           in   1                    1 = OS partition request, 0 = user request
//  req_hitmap       in   NUM_WAYS             new partition (OS requests only)
//  req_addr         in   ADDR_WIDTH           tag (user requests only)
//  rsp_valid        out  1                    response present
//  rsp_ready        in   1                    response consumed when valid&ready
//  rsp_hit          out  1                    user lookup hit
//  rsp_way          out  WAY_W                way hit or filled
//  policy_hitmap_o  out  NUM_WAYS             active partition
//  metadata_o       out  NUM_WAYS             NRU reference bits
//  all_tags_o       out  ADDR_WIDTH*NUM_WAYS  way i tag at [ADDR_WIDTH*i +: ADDR_WIDTH]
//  all_valid_o      out  NUM_WAYS             per-way valid bits
// BEHAVIOUR
//  Reset (async, any state): policy_hitmap=all ones; valid, tags, metadata = 0; FSM=IDLE;
//   rsp_valid=0, rsp_hit=0, rsp_way=0. req_ready=1 once reset_n deasserts.
//  FSM: IDLE -(req_valid)-> LOOKUP -> RESP -(rsp_ready)-> IDLE. req_ready=1 only in IDLE.
//  The request is latched on acceptance. Inputs are ignored outside IDLE.
//  Latency: accept at edge N; state updates at edge N+1; rsp_valid rises after edge N+1 (2 cycles).
//  RESP holds rsp_* stable until rsp_ready. No new request is accepted in the RESP cycle.
//  OS request with hitmap!=0: policy_hitmap<=hitmap. Tags, valid and metadata are untouched (no flush).
//   Response: rsp_hit=0, rsp_way=0.
//  OS request with hitmap==0: policy is unchanged, so policy is never zero. Response: rsp_hit=0, rsp_way=0.
//  User lookup: way i matches if policy[i] & valid[i] & tag[i]==addr. Hit way = lowest matching index.
//  User miss: victim = lowest-index invalid way in policy. If none is invalid, victim = lowest-index
//   policy way with metadata==0. If none has metadata==0, victim = lowest policy way.
//   Victim update: tag<=addr, valid<=1. Response: rsp_hit=0, rsp_way=victim.
//  NRU update (hit or fill way w): metadata[w]<=1. If every policy way's bit would then be 1,
//   clear metadata in all policy ways except w. Bits outside policy are never written.
//  Isolation invariant: a user request modifies only ways with policy[i]=1.
// TESTING
//  1 Reset: after reset -> policy=0xFF, valid=0, meta=0, rsp_valid=0, req_ready=1.
//  2 OS hitmap=0x0F, then user addr=5 -> miss, way 0. Repeat addr=5 -> hit, way 0,
//    rsp_valid two cycles after acceptance.
//  3 Policy 0x0F: fill tags 1,2,3,4 -> ways 0-3 and meta=0x08. Tag 6 -> evicts way 0, meta=0x09.
//  4 Isolation: policy 0xF0 preloaded; 20 random user requests under policy 0x0F ->
//    bits 7:4 of valid, meta and tags unchanged. OS hitmap=0x00 -> policy stays 0x0F.
//  5 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, and a pending request
//    is accepted only after the handshake.
//  6 Reset_n pulsed in LOOKUP -> immediate reset values, no fill committed, no rsp_valid.

Source files
------------

// File: rtl/partitioned_cache_set.sv
// Way-partitioned, NRU-replaced cache set responding to OS/user requests.
// Ports: clk, reset_n; req_* in (valid/ready); rsp_* out (valid/ready); state taps *_o.
module partitioned_cache_set #(
    parameter int NUM_WAYS   = 8,
    parameter int ADDR_WIDTH = 4,
    localparam int WAY_W     = $clog2(NUM_WAYS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_os,
    input  logic [NUM_WAYS-1:0]            req_hitmap,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_hit,
    output logic [WAY_W-1:0]               rsp_way,
    output logic [NUM_WAYS-1:0]            policy_hitmap_o,
    output logic [NUM_WAYS-1:0]            metadata_o,
    output logic [ADDR_WIDTH*NUM_WAYS-1:0] all_tags_o,
    output logic [NUM_WAYS-1:0]            all_valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [NUM_WAYS-1:0]   policy_q;
    logic [NUM_WAYS-1:0]   valid_q;
    logic [NUM_WAYS-1:0]   meta_q;
    logic [ADDR_WIDTH-1:0] tags_q [NUM_WAYS];

    logic                  os_q;
    logic [NUM_WAYS-1:0]   hitmap_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  has_inv;
    logic [WAY_W-1:0]      inv_way;
    logic                  has_nru;
    logic [WAY_W-1:0]      nru_way;
    logic [WAY_W-1:0]      pol_way;
    logic [WAY_W-1:0]      victim;
    logic [WAY_W-1:0]      acc_way;
    logic [NUM_WAYS-1:0]   acc_onehot;
    logic [NUM_WAYS-1:0]   meta_set;
    logic [NUM_WAYS-1:0]   meta_next;

    // Held low during reset so nothing is accepted until reset_n rises.
    assign req_ready = (state_q == IDLE) && reset_n;
    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = LOOKUP;
            LOOKUP:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Descending scans leave the lowest qualifying index in each result.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        has_nru = 1'b0;
        nru_way = '0;
        pol_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (policy_q[i]) begin
                pol_way = WAY_W'(i);
                if (valid_q[i] && tags_q[i] == addr_q) begin
                    hit     = 1'b1;
                    hit_way = WAY_W'(i);
                end
                if (!valid_q[i]) begin
                    has_inv = 1'b1;
                    inv_way = WAY_W'(i);
                end
                if (!meta_q[i]) begin
                    has_nru = 1'b1;
                    nru_way = WAY_W'(i);
                end
            end
        end
    end

    always_comb begin
        victim     = has_inv ? inv_way : (has_nru ? nru_way : pol_way);
        acc_way    = hit ? hit_way : victim;
        acc_onehot = NUM_WAYS'(1) << acc_way;
        meta_set   = meta_q | acc_onehot;
        // Saturated partition: keep only the touched way referenced.
        if ((meta_set & policy_q) == policy_q)
            meta_next = (meta_q & ~policy_q) | acc_onehot;
        else
            meta_next = meta_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            policy_q <= '1;
            valid_q  <= '0;
            meta_q   <= '0;
            for (int i = 0; i < NUM_WAYS; i++) tags_q[i] <= '0;
            os_q     <= 1'b0;
            hitmap_q <= '0;
            addr_q   <= '0;
            rsp_hit  <= 1'b0;
            rsp_way  <= '0;
        end else begin
            if (req_valid && req_ready) begin
                os_q     <= req_os;
                hitmap_q <= req_hitmap;
                addr_q   <= req_addr;
            end
            if (state_q == LOOKUP) begin
                if (os_q) begin
                    if (hitmap_q != '0) policy_q <= hitmap_q;
                    rsp_hit <= 1'b0;
                    rsp_way <= '0;
                end else begin
                    if (!hit) begin
                        tags_q[victim]  <= addr_q;
                        valid_q[victim] <= 1'b1;
                    end
                    meta_q  <= meta_next;
                    rsp_hit <= hit;
                    rsp_way <= acc_way;
                end
            end
        end
    end

    assign policy_hitmap_o = policy_q;
    assign metadata_o      = meta_q;
    assign all_valid_o     = valid_q;

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_tags
        assign all_tags_o[ADDR_WIDTH*g +: ADDR_WIDTH] = tags_q[g];
    end

endmodule

// File: tb/tb_partitioned_cache_set.sv
// Directed bench for partitioned_cache_set.
// Each task drives one scenario and checks against hand-computed values.
module tb_partitioned_cache_set;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_os = 1'b0;
    logic [7:0]  req_hitmap = '0;
    logic [3:0]  req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_hit;
    logic [2:0]  rsp_way;
    logic [7:0]  policy_hitmap_o;
    logic [7:0]  metadata_o;
    logic [31:0] all_tags_o;
    logic [7:0]  all_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    partitioned_cache_set #(.NUM_WAYS(8), .ADDR_WIDTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_os(req_os),
        .req_hitmap(req_hitmap),
        .req_addr(req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit),
        .rsp_way(rsp_way),
        .policy_hitmap_o(policy_hitmap_o),
        .metadata_o(metadata_o),
        .all_tags_o(all_tags_o),
        .all_valid_o(all_valid_o)
    );

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Issue one request, wait for its response, consume it.
    // lat counts edges from acceptance (inclusive) until rsp_valid is seen.
    task automatic do_req(input logic os, input logic [7:0] hm,
                          input logic [3:0] addr, output logic hit,
                          output logic [2:0] way, output int lat);
        int k;
        hit = 1'b0;
        way = '0;
        lat = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_os     = os;
        req_hitmap = hm;
        req_addr   = addr;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout req_ready=%0b want 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout rsp_valid=%0b want 1", rsp_valid);
        end
        hit = rsp_hit;
        way = rsp_way;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (policy_hitmap_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_policy got %h want ff", policy_hitmap_o);
        end
        n_checks++;
        if (all_valid_o !== 8'h00 || metadata_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_valid_meta got %h/%h want 00/00",
                     all_valid_o, metadata_o);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs got rv=%0b rr=%0b want 0/1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_hit_miss();
        logic h;
        logic [2:0] w;
        int lat;
        do_req(1'b1, 8'h0F, 4'd0, h, w, lat);
        n_checks++;
        if (policy_hitmap_o !== 8'h0F || h !== 1'b0 || w !== 3'd0) begin
            n_fail++;
            $display("FAIL os_load got pol=%h hit=%0b way=%0d want 0f/0/0",
                     policy_hitmap_o, h, w);
        end
        do_req(1'b0, 8'h00, 4'd5, h, w, lat);
        n_checks++;
        if (h !== 1'b0 || w !== 3'd0) begin
            n_fail++;
            $display("FAIL miss5 got hit=%0b way=%0d want 0/0", h, w);
        end
        do_req(1'b0, 8'h00, 4'd5, h, w, lat);
        n_checks++;
        if (h !== 1'b1 || w !== 3'd0) begin
            n_fail++;
            $display("FAIL hit5 got hit=%0b way=%0d want 1/0", h, w);
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL latency got %0d want 2", lat);
        end
        n_checks++;
        if (metadata_o !== 8'h01 || all_valid_o !== 8'h01) begin
            n_fail++;
            $display("FAIL hit_state got meta=%h valid=%h want 01/01",
                     metadata_o, all_valid_o);
        end
    endtask

    task automatic test_nru();
        logic h;
        logic [2:0] w;
        int lat;
        logic [3:0] t;
        do_reset();
        do_req(1'b1, 8'h0F, 4'd0, h, w, lat);
        for (int i = 0; i < 4; i++) begin
            t = 4'(i + 1);
            do_req(1'b0, 8'h00, t, h, w, lat);
            n_checks++;
            if (h !== 1'b0 || w !== 3'(i)) begin
                n_fail++;
                $display("FAIL fill%0d got hit=%0b way=%0d want 0/%0d",
                         i, h, w, i);
            end
        end
        n_checks++;
        if (metadata_o !== 8'h08) begin
            n_fail++;
            $display("FAIL nru_wrap got meta=%h want 08", metadata_o);
        end
        do_req(1'b0, 8'h00, 4'd6, h, w, lat);
        n_checks++;
        if (h !== 1'b0 || w !== 3'd0 || metadata_o !== 8'h09) begin
            n_fail++;
            $display("FAIL evict6 got hit=%0b way=%0d meta=%h want 0/0/09",
                     h, w, metadata_o);
        end
        n_checks++;
        if (all_tags_o[15:0] !== 16'h4326 || all_valid_o !== 8'h0F) begin
            n_fail++;
            $display("FAIL evict_tags got tags=%h valid=%h want 4326/0f",
                     all_tags_o[15:0], all_valid_o);
        end
    endtask

    task automatic test_isolation();
        logic h;
        logic [2:0] w;
        int lat;
        logic [3:0] a;
        do_reset();
        do_req(1'b1, 8'hF0, 4'd0, h, w, lat);
        do_req(1'b0, 8'h00, 4'd1, h, w, lat);
        do_req(1'b0, 8'h00, 4'd2, h, w, lat);
        do_req(1'b0, 8'h00, 4'd3, h, w, lat);
        n_checks++;
        if (w !== 3'd6 || all_valid_o !== 8'h70 || metadata_o !== 8'h70) begin
            n_fail++;
            $display("FAIL preload got way=%0d valid=%h meta=%h want 6/70/70",
                     w, all_valid_o, metadata_o);
        end
        do_req(1'b1, 8'h0F, 4'd0, h, w, lat);
        do_req(1'b0, 8'h00, 4'd1, h, w, lat);
        n_checks++;
        if (h !== 1'b0 || w !== 3'd0) begin
            n_fail++;
            $display("FAIL foreign_tag got hit=%0b way=%0d want 0/0", h, w);
        end
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom_range(0, 15));
            do_req(1'b0, 8'h00, a, h, w, lat);
        end
        n_checks++;
        if (all_valid_o[7:4] !== 4'h7 || metadata_o[7:4] !== 4'h7) begin
            n_fail++;
            $display("FAIL iso_bits got valid=%h meta=%h want 7/7",
                     all_valid_o[7:4], metadata_o[7:4]);
        end
        n_checks++;
        if (all_tags_o[31:16] !== 16'h0321) begin
            n_fail++;
            $display("FAIL iso_tags got %h want 0321", all_tags_o[31:16]);
        end
        do_req(1'b1, 8'h00, 4'd0, h, w, lat);
        n_checks++;
        if (policy_hitmap_o !== 8'h0F || h !== 1'b0 || w !== 3'd0) begin
            n_fail++;
            $display("FAIL os_zero got pol=%h hit=%0b way=%0d want 0f/0/0",
                     policy_hitmap_o, h, w);
        end
    endtask

    task automatic test_backpressure();
        logic h;
        logic [2:0] w;
        int lat;
        do_reset();
        do_req(1'b1, 8'h0F, 4'd0, h, w, lat);
        @(negedge clk);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_os     = 1'b0;
        req_addr   = 4'd7;
        @(posedge clk);
        #1;
        req_os     = 1'b1;
        req_hitmap = 8'h03;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_way !== 3'd0 ||
                req_ready !== 1'b0 || policy_hitmap_o !== 8'h0F) begin
                n_fail++;
                $display("FAIL stall%0d got rv=%0b hit=%0b way=%0d rr=%0b pol=%h want 1/0/0/0/0f",
                         i, rsp_valid, rsp_hit, rsp_way, req_ready, policy_hitmap_o);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release got rv=%0b rr=%0b want 0/1",
                     rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || policy_hitmap_o !== 8'h03) begin
            n_fail++;
            $display("FAIL pending got rv=%0b pol=%h want 1/03",
                     rsp_valid, policy_hitmap_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_lookup();
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_os    = 1'b0;
        req_addr  = 4'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 ||
            policy_hitmap_o !== 8'hFF || all_valid_o !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset got rv=%0b rr=%0b pol=%h valid=%h want 0/0/ff/00",
                     rsp_valid, req_ready, policy_hitmap_o, all_valid_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b0 || all_valid_o !== 8'h00 || metadata_o !== 8'h00) begin
                n_fail++;
                $display("FAIL post_reset%0d got rv=%0b valid=%h meta=%h want 0/00/00",
                         i, rsp_valid, all_valid_o, metadata_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_miss();
        test_nru();
        test_isolation();
        test_backpressure();
        test_reset_lookup();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
